hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Pipeline sequencer for the 5-stage MIPS core.
- Decides per cycle which pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) advance, hold or bubble, and when the PC updates.
- Covers load-use hazards that operand forwarding cannot resolve, instruction and data memory waits, taken-branch/jump squashes, and halt drain.
- Sits beside the forwarding unit; its outputs drive the latch enable and flush inputs and the PC enable.

Parameters:
- REG_W, 5, register index width (regbits).
- DRAIN_CYCLES, 2, cycles between halt seen in MEM and halt_out assertion.

Ports:
- CLK  input  1  core clock, rising edge
- RST  input  1  asynchronous, active-high reset
- idex_memread  input  1  instruction in EX is a load
- idex_rd  input  REG_W  destination of the instruction in EX
- ifid_rs  input  REG_W  rs of the instruction in ID
- ifid_rt  input  REG_W  rt of the instruction in ID
- ifid_uses_rt  input  1  ID instruction reads rt
- redirect  input  1  taken branch or jump resolved in MEM
- ihit  input  1  instruction fetch complete
- dmem_req  input  1  MEM-stage instruction issues a load or store
- dhit  input  1  data access complete
- halt_mem  input  1  halt instruction in MEM
- pc_en  output  1  PC loads its next value
- ifid_en, idex_en, exmem_en, memwb_en  output  1 each  latch advance
- ifid_flush, idex_flush, memwb_flush  output  1 each  latch loads a bubble
- halt_out  output  1  core halted (sticky)

Behaviour:
- Registered FSM states: RUN, DWAIT, REDIR_PEND, DRAIN, HALTED. Drain counter is 2 bits, cleared on every entry to DRAIN.
- Outputs are combinational from state and inputs. Flush overrides enable on the same latch.
- RST asserted: state=RUN, counter=0, halt_out=0. All enables and flushes read 0 while RST is high.
- Priority, highest first: HALTED, DRAIN, data wait, redirect, load-use, imiss, normal.
- Data wait (dmem_req & ~dhit, or state DWAIT):
  - pc_en, ifid_en, idex_en and exmem_en are 0; memwb_flush=1.
  - State is DWAIT while dhit=0. On dhit=1, treat the cycle as RUN.
  - A redirect seen during DWAIT is not lost; it is taken in the dhit cycle.
- Redirect (redirect=1 and no data wait):
  - ifid_flush=1, idex_flush=1, exmem_flush-free path (EX/MEM advances), pc_en=1 if ihit.
  - If ihit=0: state goes to REDIR_PEND; pc_en=0; ifid_flush stays 1 each cycle until ihit=1, then pc_en=1 and state returns to RUN.
- Load-use (idex_memread & idex_rd!=0 & (idex_rd==ifid_rs | (ifid_uses_rt & idex_rd==ifid_rt))):
  - pc_en=0, ifid_en=0, idex_flush=1; later stages advance.
  - Produces exactly one bubble, because the load moves to MEM on the next cycle.
- Imiss (ihit=0 only): pc_en=0, ifid_flush=1; ID/EX, EX/MEM and MEM/WB advance.
- Normal: all enables are 1, all flushes are 0.
- halt_mem=1 with no data wait:
  - Enter DRAIN. pc_en=0 and ifid_flush=1 from this cycle onward.
  - Later stages advance for DRAIN_CYCLES cycles, then enter HALTED.
- HALTED: all enables 0, halt_out=1; leaves only on RST.
- RST mid-DWAIT or mid-DRAIN returns immediately to RUN and discards pending redirects.
- Register 0 never causes a load-use stall.

Optional Feature:
- Macro HAZARD_PERF_EN adds output ports stall_cycles[31:0] and squash_count[15:0].
  - stall_cycles increments on any cycle with pc_en=0 in RUN, DWAIT or REDIR_PEND.
  - squash_count increments once per redirect event, not per cycle.
  - Both counters are cleared by RST and saturate at all ones.
- Without the macro, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Load-use: idex_memread=1, idex_rd=5, ifid_rs=5, ihit=1 → one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle (memread=0) all enables are 1.
- Rd zero: idex_memread=1, idex_rd=0, ifid_rs=0 → no stall; pc_en=1.
- Data wait with redirect: dmem_req=1, dhit=0 for 3 cycles, redirect=1 throughout → memwb_flush=1 for 3 cycles with exmem_en=0. Cycle 4 (dhit=1) → ifid_flush=1, idex_flush=1, pc_en=1.
- Redirect with imiss: redirect=1, ihit=0 for 2 cycles, then ihit=1 → REDIR_PEND, ifid_flush held 1. pc_en=1 only in the ihit cycle, then RUN.
- Halt drain: halt_mem=1 → pc_en=0 immediately, memwb_en=1 for 2 cycles, then halt_out=1 and all enables 0. Holds for 10 further cycles.
- Async reset: assert RST mid-DWAIT, between clock edges → outputs 0 immediately. After release, state RUN and pc_en=1 with ihit=1.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the 5-stage MIPS core: latch advance/hold/bubble and PC enable.
// Optional build macro HAZARD_PERF_EN adds stall_cycles / squash_count counters.
module hazard_control_unit #(
   parameter int REG_W        = 5,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             idex_memread,
   input  logic [REG_W-1:0] idex_rd,
   input  logic [REG_W-1:0] ifid_rs,
   input  logic [REG_W-1:0] ifid_rt,
   input  logic             ifid_uses_rt,
   input  logic             redirect,
   input  logic             ihit,
   input  logic             dmem_req,
   input  logic             dhit,
   input  logic             halt_mem,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             memwb_flush,
   output logic             halt_out,
   output logic [2:0]       dbg_state
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]      stall_cycles,
   output logic [15:0]      squash_count
`endif
);

   localparam logic [2:0] ST_RUN        = 3'd0;
   localparam logic [2:0] ST_DWAIT      = 3'd1;
   localparam logic [2:0] ST_REDIR_PEND = 3'd2;
   localparam logic [2:0] ST_DRAIN      = 3'd3;
   localparam logic [2:0] ST_HALTED     = 3'd4;

   // The halt cycle itself is the first drain cycle, so DRAIN lasts DRAIN_CYCLES-1 cycles.
   localparam logic [1:0] DRAIN_LAST = (DRAIN_CYCLES >= 2) ? 2'(DRAIN_CYCLES - 2) : 2'd0;

   logic [2:0] r_state;
   logic [1:0] r_cnt;
   logic       r_redir_pend;

   logic [2:0] w_next_state;
   logic [1:0] w_next_cnt;
   logic       w_next_pend;
   logic       w_dwait;
   logic       w_redir_req;
   logic       w_load_use;
   logic       w_redir_evt;
   logic       w_pc_en;
   logic       w_ifid_adv, w_idex_adv, w_exmem_adv, w_memwb_adv;
   logic       w_ifid_fl, w_idex_fl, w_memwb_fl;

   assign w_dwait     = ~dhit & (dmem_req | (r_state == ST_DWAIT));
   assign w_redir_req = redirect | r_redir_pend | (r_state == ST_REDIR_PEND);
   assign w_load_use  = idex_memread & (idex_rd != '0) &
                        ((idex_rd == ifid_rs) | (ifid_uses_rt & (idex_rd == ifid_rt)));

   always_comb begin
      w_pc_en      = 1'b0;
      w_ifid_adv   = 1'b0;
      w_idex_adv   = 1'b0;
      w_exmem_adv  = 1'b0;
      w_memwb_adv  = 1'b0;
      w_ifid_fl    = 1'b0;
      w_idex_fl    = 1'b0;
      w_memwb_fl   = 1'b0;
      w_redir_evt  = 1'b0;
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_next_pend  = r_redir_pend;
      if (r_state == ST_HALTED) begin
         w_next_state = ST_HALTED;
      end else if (r_state == ST_DRAIN) begin
         w_ifid_fl   = 1'b1;
         w_idex_adv  = 1'b1;
         w_exmem_adv = 1'b1;
         w_memwb_adv = 1'b1;
         if (r_cnt == DRAIN_LAST) begin
            w_next_state = ST_HALTED;
         end else begin
            w_next_cnt = r_cnt + 2'd1;
         end
      end else if (w_dwait) begin
         // Everything up to EX/MEM freezes; a redirect arriving now is remembered.
         w_memwb_fl   = 1'b1;
         w_next_state = ST_DWAIT;
         w_next_pend  = w_redir_req;
      end else if (halt_mem) begin
         w_ifid_fl    = 1'b1;
         w_idex_adv   = 1'b1;
         w_exmem_adv  = 1'b1;
         w_memwb_adv  = 1'b1;
         w_next_state = (DRAIN_CYCLES <= 1) ? ST_HALTED : ST_DRAIN;
         w_next_cnt   = 2'd0;
         w_next_pend  = 1'b0;
      end else if (w_redir_req) begin
         w_ifid_fl    = 1'b1;
         w_idex_fl    = 1'b1;
         w_exmem_adv  = 1'b1;
         w_memwb_adv  = 1'b1;
         w_pc_en      = ihit;
         w_redir_evt  = (r_state != ST_REDIR_PEND);
         w_next_state = ihit ? ST_RUN : ST_REDIR_PEND;
         w_next_pend  = 1'b0;
      end else if (w_load_use) begin
         w_idex_fl    = 1'b1;
         w_exmem_adv  = 1'b1;
         w_memwb_adv  = 1'b1;
         w_next_state = ST_RUN;
      end else if (!ihit) begin
         w_ifid_fl    = 1'b1;
         w_idex_adv   = 1'b1;
         w_exmem_adv  = 1'b1;
         w_memwb_adv  = 1'b1;
         w_next_state = ST_RUN;
      end else begin
         w_pc_en      = 1'b1;
         w_ifid_adv   = 1'b1;
         w_idex_adv   = 1'b1;
         w_exmem_adv  = 1'b1;
         w_memwb_adv  = 1'b1;
         w_next_state = ST_RUN;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state      <= ST_RUN;
         r_cnt        <= 2'd0;
         r_redir_pend <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_cnt        <= w_next_cnt;
         r_redir_pend <= w_next_pend;
      end
   end

   // Flush wins over enable on the same latch; reset forces every control low.
   assign pc_en       = ~RST & w_pc_en;
   assign ifid_en     = ~RST & w_ifid_adv & ~w_ifid_fl;
   assign idex_en     = ~RST & w_idex_adv & ~w_idex_fl;
   assign exmem_en    = ~RST & w_exmem_adv;
   assign memwb_en    = ~RST & w_memwb_adv & ~w_memwb_fl;
   assign ifid_flush  = ~RST & w_ifid_fl;
   assign idex_flush  = ~RST & w_idex_fl;
   assign memwb_flush = ~RST & w_memwb_fl;
   assign halt_out    = ~RST & (r_state == ST_HALTED);
   assign dbg_state   = r_state;

`ifdef HAZARD_PERF_EN
   logic r_unused_guard;
   logic w_stall_st;
   logic [31:0] r_stall_cycles;
   logic [15:0] r_squash_count;

   assign w_stall_st = (r_state == ST_RUN) | (r_state == ST_DWAIT) | (r_state == ST_REDIR_PEND);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_stall_cycles <= '0;
         r_squash_count <= '0;
         r_unused_guard <= 1'b0;
      end else begin
         r_unused_guard <= 1'b0;
         if (w_stall_st && !w_pc_en && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
         end
         if (w_redir_evt && (r_squash_count != '1)) begin
            r_squash_count <= r_squash_count + 16'd1;
         end
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign squash_count = r_squash_count;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed, table-driven bench for hazard_control_unit plus multi-cycle corner sequences.
module tb_hazard_control_unit;

   localparam logic [2:0] ST_RUN        = 3'd0;
   localparam logic [2:0] ST_DWAIT      = 3'd1;
   localparam logic [2:0] ST_REDIR_PEND = 3'd2;
   localparam logic [2:0] ST_DRAIN      = 3'd3;
   localparam logic [2:0] ST_HALTED     = 3'd4;

   // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush, halt_out}
   localparam logic [8:0] EXP_ZERO   = 9'b00000_000_0;
   localparam logic [8:0] EXP_NORM   = 9'b11111_000_0;
   localparam logic [8:0] EXP_LU     = 9'b00011_010_0;
   localparam logic [8:0] EXP_IMISS  = 9'b00111_100_0;
   localparam logic [8:0] EXP_REDIR  = 9'b10011_110_0;
   localparam logic [8:0] EXP_RPEND  = 9'b00011_110_0;
   localparam logic [8:0] EXP_DWAIT  = 9'b00000_001_0;
   localparam logic [8:0] EXP_HALTC  = 9'b00111_100_0;
   localparam logic [8:0] EXP_HALTED = 9'b00000_000_1;

   logic       CLK, RST;
   logic       idex_memread, ifid_uses_rt, redirect, ihit, dmem_req, dhit, halt_mem;
   logic [4:0] idex_rd, ifid_rs, ifid_rt;
   logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic       ifid_flush, idex_flush, memwb_flush, halt_out;
   logic [2:0] dbg_state;
   logic [8:0] w_out;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       memread;
      logic [4:0] rd, rs, rt;
      logic       uses_rt, redir, ih, dreq, dh, halt;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[15];

   hazard_control_unit #(.REG_W(5), .DRAIN_CYCLES(2)) dut (
      .CLK(CLK), .RST(RST),
      .idex_memread(idex_memread), .idex_rd(idex_rd), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
      .ifid_uses_rt(ifid_uses_rt), .redirect(redirect), .ihit(ihit),
      .dmem_req(dmem_req), .dhit(dhit), .halt_mem(halt_mem),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
      .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .memwb_flush(memwb_flush), .halt_out(halt_out), .dbg_state(dbg_state)
   );

   assign w_out = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, memwb_flush, halt_out};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [8:0] exp);
      n_checks++;
      if (w_out !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", nm, w_out, exp);
      end
   endtask

   task automatic chk_state(input string nm, input logic [2:0] exp);
      n_checks++;
      if (dbg_state !== exp) begin
         n_fail++;
         $display("FAIL %s: state got %0d expected %0d", nm, dbg_state, exp);
      end
   endtask

   task automatic idle();
      idex_memread = 0; idex_rd = 0; ifid_rs = 0; ifid_rt = 0; ifid_uses_rt = 0;
      redirect = 0; ihit = 1; dmem_req = 0; dhit = 0; halt_mem = 0;
   endtask

   task automatic cyc();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   initial begin
      RST = 1'b1;
      idle();
      //                memrd rd     rs     rt     usert redir ih dreq dh halt expected
      vecs[0]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, EXP_NORM};
      vecs[1]  = '{1'b1, 5'd5, 5'd5, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, EXP_LU};
      vecs[2]  = '{1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, EXP_LU};
      vecs[3]  = '{1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, EXP_NORM};
      vecs[4]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, EXP_NORM};
      vecs[5]  = '{1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, EXP_NORM};
      vecs[6]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, EXP_IMISS};
      vecs[7]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, EXP_REDIR};
      vecs[8]  = '{1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, EXP_REDIR};
      vecs[9]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, EXP_DWAIT};
      vecs[10] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, EXP_NORM};
      vecs[11] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, EXP_DWAIT};
      vecs[12] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, EXP_HALTC};
      vecs[13] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, EXP_DWAIT};
      vecs[14] = '{1'b1, 5'd31, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, EXP_LU};

      // Reset state
      repeat (2) @(negedge CLK);
      #1 chk("reset_outputs", EXP_ZERO);
      chk_state("reset_state", ST_RUN);
      RST = 1'b0;
      #1 chk("after_reset_norm", EXP_NORM);
      @(negedge CLK);

      // Single-cycle decisions from RUN; an async reset pulse keeps each vector unclocked
      for (int i = 0; i < 15; i++) begin
         idex_memread = vecs[i].memread; idex_rd = vecs[i].rd;
         ifid_rs = vecs[i].rs; ifid_rt = vecs[i].rt; ifid_uses_rt = vecs[i].uses_rt;
         redirect = vecs[i].redir; ihit = vecs[i].ih; dmem_req = vecs[i].dreq;
         dhit = vecs[i].dh; halt_mem = vecs[i].halt;
         #1 chk($sformatf("vec%0d", i), vecs[i].exp);
         idle();
         RST = 1'b1;
         #1 RST = 1'b0;
         @(negedge CLK);
      end

      // Load-use gives exactly one bubble
      idex_memread = 1; idex_rd = 5; ifid_rs = 5;
      #1 chk("lu_stall", EXP_LU);
      cyc();
      idle();
      #1 chk("lu_release", EXP_NORM);
      cyc();

      // Data wait with redirect: held throughout (v=0) or only in the first cycle (v=1)
      for (int v = 0; v < 2; v++) begin
         dmem_req = 1; dhit = 0; redirect = 1;
         for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("dw%0d_wait%0d", v, c), EXP_DWAIT);
            cyc();
            chk_state($sformatf("dw%0d_state%0d", v, c), ST_DWAIT);
            if (v == 1) redirect = 0;
         end
         dhit = 1;
         #1 chk($sformatf("dw%0d_hit", v), EXP_REDIR);
         cyc();
         idle();
         #1 chk($sformatf("dw%0d_after", v), EXP_NORM);
         chk_state($sformatf("dw%0d_run", v), ST_RUN);
         cyc();
      end

      // Redirect during an instruction miss
      redirect = 1; ihit = 0;
      #1 chk("rp_first", EXP_RPEND);
      cyc();
      chk_state("rp_state1", ST_REDIR_PEND);
      #1 chk("rp_second", EXP_RPEND);
      cyc();
      chk_state("rp_state2", ST_REDIR_PEND);
      redirect = 0; ihit = 1;
      #1 chk("rp_ihit", EXP_REDIR);
      cyc();
      chk_state("rp_run", ST_RUN);
      #1 chk("rp_after", EXP_NORM);
      cyc();

      // Reset in the middle of a drain
      halt_mem = 1;
      #1 chk("rd_halt", EXP_HALTC);
      cyc();
      halt_mem = 0;
      chk_state("rd_drain", ST_DRAIN);
      RST = 1'b1;
      #1 chk("rd_rst_out", EXP_ZERO);
      RST = 1'b0;
      #1 chk_state("rd_run", ST_RUN);
      chk("rd_norm", EXP_NORM);
      cyc();

      // Async reset mid-DWAIT discards the pending redirect
      dmem_req = 1; dhit = 0; redirect = 1;
      #1 chk("ar_wait", EXP_DWAIT);
      cyc();
      redirect = 0;
      chk_state("ar_dwait", ST_DWAIT);
      #1 RST = 1'b1;
      #1 chk("ar_rst_out", EXP_ZERO);
      chk_state("ar_rst_state", ST_RUN);
      RST = 1'b0;
      dmem_req = 0;
      #1 chk("ar_release", EXP_NORM);
      cyc();
      #1 chk("ar_no_pend", EXP_NORM);
      chk_state("ar_run", ST_RUN);
      cyc();

      // Halt drain then sticky halt
      halt_mem = 1;
      #1 chk("hd_c0", EXP_HALTC);
      cyc();
      halt_mem = 0;
      #1 chk("hd_c1", EXP_HALTC);
      cyc();
      for (int c = 0; c < 11; c++) begin
         ihit = 1'($urandom_range(0, 1));
         redirect = 1'($urandom_range(0, 1));
         dmem_req = 1'($urandom_range(0, 1));
         halt_mem = 1'($urandom_range(0, 1));
         #1 chk($sformatf("hd_halted%0d", c), EXP_HALTED);
         chk_state($sformatf("hd_state%0d", c), ST_HALTED);
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
